// File: rtl/mem_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : mem_pkg
//  Description : Shared store-type encodings, controller state enum and a
//                helper that maps a store funct3 to its access size in bytes.
//  Revision    : 1.0 - initial release
// ============================================================================
package mem_pkg;

    localparam logic [2:0] F3_SB = 3'b000;
    localparam logic [2:0] F3_SH = 3'b001;
    localparam logic [2:0] F3_SW = 3'b010;
    localparam logic [2:0] F3_SD = 3'b011;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_BEAT0 = 2'd1,
        ST_BEAT1 = 2'd2,
        ST_RESP  = 2'd3
    } store_state_t;

    // Access size in bytes; 0 marks an encoding that is never a store.
    function automatic logic [3:0] store_size(input logic [2:0] f3);
        case (f3)
            F3_SB:   store_size = 4'd1;
            F3_SH:   store_size = 4'd2;
            F3_SW:   store_size = 4'd4;
            F3_SD:   store_size = 4'd8;
            default: store_size = 4'd0;
        endcase
    endfunction

endpackage
`default_nettype wire

// File: rtl/store_lane_align.sv
`default_nettype none
// ============================================================================
//  Module      : store_lane_align
//  Description : Purely combinational lane placement for a store. Produces a
//                two-beat byte-enable mask and two-beat data image, plus
//                illegal-type and misalignment flags.
//  Revision    : 1.0 - initial release
// ============================================================================
module store_lane_align
    import mem_pkg::*;
#(
    parameter int DATA_W = 32,
    localparam int NB    = DATA_W / 8,
    localparam int OFF_W = $clog2(NB)
) (
    input  logic [2:0]          iFunct3,
    input  logic [OFF_W-1:0]    iOff,
    input  logic [DATA_W-1:0]   iData,
    output logic [2*NB-1:0]     oMask,
    output logic [2*DATA_W-1:0] oData,
    output logic                oIllegal,
    output logic                oMisaligned
);

    logic [3:0]          sz;
    logic [3:0]          off4;
    logic [2*DATA_W-1:0] shifted;

    // Mask covers bytes [off, off+size); disabled lanes are forced to zero so
    // stale upper bits of a narrow store never reach the bus.
    always_comb begin
        sz          = store_size(iFunct3);
        off4        = 4'(iOff);
        oIllegal    = (sz == 4'd0) || ((sz == 4'd8) && (DATA_W != 64));
        oMisaligned = |(off4 & (sz - 4'd1));
        shifted     = {{DATA_W{1'b0}}, iData} << {iOff, 3'b000};
        oMask       = '0;
        oData       = '0;
        for (int b = 0; b < 2*NB; b++) begin
            oMask[b] = (b >= int'(off4)) && (b < int'(off4) + int'(sz));
            oData[8*b +: 8] = oMask[b] ? shifted[8*b +: 8] : 8'h00;
        end
    end

endmodule
`default_nettype wire

// File: rtl/mem_store_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : mem_store_ctrl
//  Description : Store controller. Accepts one store request at a time,
//                issues one or two aligned memory beats (or flags an
//                exception) and signals completion with a one-cycle pulse.
//  Revision    : 1.0 - initial release
// ============================================================================
module mem_store_ctrl
    import mem_pkg::*;
#(
    parameter int DATA_W         = 32,
    parameter int ADDR_W         = 32,
    parameter int MISALIGN_SPLIT = 1
) (
    input  logic                iCLK,
    input  logic                iRST,
    input  logic                iReqValid,
    output logic                oReqReady,
    input  logic [2:0]          iFunct3,
    input  logic [ADDR_W-1:0]   iAddr,
    input  logic [DATA_W-1:0]   iData,
    output logic                oMemValid,
    input  logic                iMemReady,
    output logic [ADDR_W-1:0]   oMemAddr,
    output logic [DATA_W-1:0]   oMemData,
    output logic [DATA_W/8-1:0] oMemByteEnable,
    output logic                oDone,
    output logic                oException,
    output logic                oBusy
);

    localparam int NB    = DATA_W / 8;
    localparam int OFF_W = $clog2(NB);

    store_state_t        state_q;
    logic [ADDR_W-1:0]   addr_q;
    logic [2*NB-1:0]     mask_q;
    logic [2*DATA_W-1:0] data_q;
    logic                exc_q;

    logic [2*NB-1:0]     lane_mask;
    logic [2*DATA_W-1:0] lane_data;
    logic                lane_illegal;
    logic                lane_misaligned;
    logic                reject;

    store_lane_align #(.DATA_W(DATA_W)) u_align (
        .iFunct3     (iFunct3),
        .iOff        (iAddr[OFF_W-1:0]),
        .iData       (iData),
        .oMask       (lane_mask),
        .oData       (lane_data),
        .oIllegal    (lane_illegal),
        .oMisaligned (lane_misaligned)
    );

    assign reject = lane_illegal || (lane_misaligned && (MISALIGN_SPLIT == 0));

    // Controller FSM; the aligned beat image is captured once at acceptance.
    always_ff @(posedge iCLK or posedge iRST) begin
        if (iRST) begin
            state_q <= ST_IDLE;
            addr_q  <= '0;
            mask_q  <= '0;
            data_q  <= '0;
            exc_q   <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (iReqValid) begin
                        if (reject) begin
                            exc_q   <= 1'b1;
                            mask_q  <= '0;
                            data_q  <= '0;
                            state_q <= ST_RESP;
                        end else begin
                            exc_q   <= 1'b0;
                            addr_q  <= {iAddr[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
                            mask_q  <= lane_mask;
                            data_q  <= lane_data;
                            state_q <= ST_BEAT0;
                        end
                    end
                end
                ST_BEAT0: begin
                    if (iMemReady) begin
                        state_q <= (|mask_q[2*NB-1:NB]) ? ST_BEAT1 : ST_RESP;
                    end
                end
                ST_BEAT1: begin
                    if (iMemReady) begin
                        state_q <= ST_RESP;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    // Outputs decode straight from state registers so reset clears them at once.
    always_comb begin
        oReqReady      = (state_q == ST_IDLE) && !iRST;
        oBusy          = (state_q != ST_IDLE);
        oDone          = (state_q == ST_RESP);
        oException     = (state_q == ST_RESP) && exc_q;
        oMemValid      = 1'b0;
        oMemAddr       = '0;
        oMemData       = '0;
        oMemByteEnable = '0;
        if (state_q == ST_BEAT0) begin
            oMemValid      = 1'b1;
            oMemAddr       = addr_q;
            oMemData       = data_q[DATA_W-1:0];
            oMemByteEnable = mask_q[NB-1:0];
        end else if (state_q == ST_BEAT1) begin
            oMemValid      = 1'b1;
            oMemAddr       = addr_q + ADDR_W'(NB);
            oMemData       = data_q[2*DATA_W-1:DATA_W];
            oMemByteEnable = mask_q[2*NB-1:NB];
        end
    end

endmodule
`default_nettype wire

// File: doc/mem_store_ctrl.md
MEM_STORE_CTRL -- requirements
Module: mem_store_ctrl

Interface
REQ-001 SHALL have parameter DATA_W, default 32, meaning bus/data width: 32 or 64; NB = DATA_W/8 byte lanes.
REQ-002 SHALL have parameter ADDR_W, default 32, meaning byte-address width.
REQ-003 SHALL have parameter MISALIGN_SPLIT, default 1, meaning 1 = split misaligned store into two aligned beats and 0 = raise exception.
REQ-004 SHALL have ports: iCLK  in  1  sole clock; all state on rising edge.
REQ-005 SHALL have ports: iRST  in  1  reset, asynchronous, active-high.
REQ-006 SHALL have ports: iReqValid  in  1  store request valid.
REQ-007 SHALL have ports: oReqReady  out  1  request accepted when iReqValid & oReqReady.
REQ-008 SHALL have ports: iFunct3  in  3  store type: 000 SB, 001 SH, 010 SW, 011 SD (SD only when DATA_W=64).
REQ-009 SHALL have ports: iAddr  in  ADDR_W  byte address; iData  in  DATA_W  store data, low-aligned.
REQ-010 SHALL have ports: oMemValid  out  1  memory beat valid; iMemReady  in  1  memory accepts beat.
REQ-011 SHALL have ports: oMemAddr  out  ADDR_W  NB-aligned beat address; oMemData  out  DATA_W  lane-positioned data; oMemByteEnable  out  NB  lane enables.
REQ-012 SHALL have ports: oDone  out  1  one-cycle completion pulse; oException  out  1  misalign/illegal flag, valid only with oDone; oBusy  out  1  state != IDLE.

Function
REQ-013 SHALL implement FSM states IDLE, BEAT0, BEAT1, RESP.
REQ-014 SHALL drive oReqReady = 1 only in IDLE with iRST low, and latch funct3/addr/data on acceptance.
REQ-015 On acceptance, illegal funct3 SHALL go to RESP with exception set and no memory beat.
REQ-016 On acceptance, misaligned access (address not a multiple of size) with MISALIGN_SPLIT=0 SHALL go to RESP with exception set and no memory beat.
REQ-017 Otherwise SHALL compute off = addr mod NB, a 2*NB mask = ((1<<size)-1)<<off, and 2*DATA_W data = iData<<(8*off); then go to BEAT0.
REQ-018 BEAT0 SHALL present addr&~(NB-1), low mask half, and low data half.
REQ-019 BEAT1 SHALL present (aligned addr + NB) mod 2^ADDR_W, high mask half, and high data half.
REQ-020 Lanes whose enable is 0 SHALL drive data 0; no byte replication.
REQ-021 oMemValid SHALL be 1 in BEAT0/BEAT1, and addr/data/BE SHALL be held stable until iMemReady.
REQ-022 On iMemReady, BEAT0 SHALL go to BEAT1 if high mask nonzero, else RESP; BEAT1 SHALL go to RESP.
REQ-023 RESP SHALL assert oDone for exactly one cycle with oException, then return to IDLE.
REQ-024 Latency, ready=1: aligned store accept at cycle 0, beat at 1, oDone at 2; split store oDone at 3; exception oDone at 1.
REQ-025 oMemValid, oMemByteEnable and oMemData SHALL be 0 in IDLE and RESP.
REQ-026 No request SHALL be accepted while busy; a request arriving during RESP waits until IDLE.

Reset
REQ-027 iRST high SHALL immediately force IDLE, including mid-beat, drop in-flight beat, and generate no oDone.
REQ-028 Reset values SHALL be: oMemValid=0, oMemAddr=0, oMemData=0, oMemByteEnable=0, oDone=0, oException=0, oBusy=0, oReqReady=0 while iRST high.

Structure
REQ-029 Funct3 store constants and the state enum SHALL live in shared package mem_pkg.
REQ-030 Lane mask/data shifting SHALL be one combinational sub-module, store_lane_align; the FSM and registers SHALL be in mem_store_ctrl.

Verification (DATA_W=32, iMemReady=1 unless stated)
REQ-031 SW 0x100, 0xDEADBEEF -> one beat: addr 0x100, BE 1111, data DEADBEEF; oDone at cycle 2; oException 0.
REQ-032 SB 0x203, 0x000000A5 -> addr 0x200, BE 1000, data A5000000; oDone at cycle 2.
REQ-033 SW 0x102, 0x11223344, SPLIT=1 -> beat0 addr 0x100, BE 1100, data 33440000; beat1 addr 0x104, BE 0011, data 00001122; oDone at cycle 3.
REQ-034 Same store with SPLIT=0, and funct3=011 -> no oMemValid; oDone=oException=1 at cycle 1.
REQ-035 SH 0x0FE with iMemReady low 3 cycles -> beat outputs stable for all 3 cycles; oDone 1 cycle after ready.
REQ-036 iRST pulsed during BEAT1 -> oMemValid 0 same cycle; no oDone; next request behaves as after reset.
